// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst of writes into a sync FIFO.
// Latency: 1 cycle to grant from IDLE; beats pass combinationally (0 cycles) while granted.
// Backpressure: fifo_full stalls the burst holding the grant; fifo_ready low ends the burst.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  input  logic                          fifo_ready,
  output logic                          busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IW-1:0]      gidx, gidx_nxt;
  logic [IW-1:0]      last_grant, last_grant_nxt;
  logic [CW-1:0]      beat_cnt, beat_cnt_nxt;
  logic [IW-1:0]      pick;
  logic               found;
  logic               beat;
  int                 cand;

  // Search upward from the requester after the last owner, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  assign beat = (state == BURST) && req_valid[gidx] && !fifo_full && fifo_ready;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    gidx_nxt       = gidx;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (fifo_ready && found) begin
          state_nxt    = BURST;
          grant_nxt    = NUM_REQ'(1) << pick;
          gidx_nxt     = pick;
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        // A full FIFO alone never ends the burst; the owner keeps the grant.
        if (!req_valid[gidx] || !fifo_ready || (beat && beat_cnt == LAST_BEAT)) begin
          state_nxt      = IDLE;
          grant_nxt      = '0;
          last_grant_nxt = gidx;
        end else if (beat) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      gidx       <= gidx_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  assign busy       = (state == BURST);
  assign fifo_wr_en = beat;
  assign req_ready  = beat ? grant : '0;

  // Mux keyed by the registered one-hot grant so the data path never sees a transient owner.
  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) fifo_wr_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter with a per-requester sequence scoreboard.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] grant;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_wr_data;
  logic          fifo_full;
  logic          fifo_ready;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full), .fifo_ready(fifo_ready),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  function automatic logic [W-1:0] dval(input int i);
    return W'(32'hA000_0000 + i);
  endfunction

  function automatic int oh2i(input logic [NR-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_wr_en"}, 64'(fifo_wr_en), 64'(0));
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic check_beat(input string tag, input int idx, input int cnt);
    logic [NR-1:0] oh;
    oh = NR'(1) << idx;
    chk({tag, "_grant"}, 64'(grant), 64'(oh));
    chk({tag, "_wr_en"}, 64'(fifo_wr_en), 64'(1));
    chk({tag, "_ready"}, 64'(req_ready), 64'(oh));
    chk({tag, "_data"}, 64'(fifo_wr_data), 64'(dval(idx)));
    chk({tag, "_beat_cnt"}, 64'(dut.beat_cnt), 64'(cnt));
  endtask

  task automatic check_stall(input string tag, input int idx, input int cnt);
    chk({tag, "_grant"}, 64'(grant), 64'(NR'(1) << idx));
    chk({tag, "_wr_en"}, 64'(fifo_wr_en), 64'(0));
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    chk({tag, "_beat_cnt"}, 64'(dut.beat_cnt), 64'(cnt));
  endtask

  initial begin
    int writes;
    int seq [NR];
    int starve [NR];
    logic [NR-1:0] prev_valid;
    logic [NR-1:0] prev_grant;
    int idx;

    rst        = 1'b1;
    req_valid  = '0;
    fifo_full  = 1'b0;
    fifo_ready = 1'b0;
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = dval(i);

    // Reset state
    tick; tick; settle;
    check_idle("reset");
    chk("reset_beat_cnt", 64'(dut.beat_cnt), 64'(0));
    chk("reset_last_grant", 64'(dut.last_grant), 64'(NR - 1));

    // No grant while the FIFO is still initialising
    tick;
    rst       = 1'b0;
    req_valid = 4'b1111;
    settle;
    check_idle("not_ready0");
    for (int c = 0; c < 3; c++) begin
      tick; settle;
      check_idle("not_ready");
    end
    tick;
    fifo_ready = 1'b1;
    settle;
    check_idle("ready_arb_cycle");

    // Requester 0: full burst, idle gap, then requester 1
    for (int b = 0; b < MB; b++) begin
      tick; settle;
      check_beat("r0_burst", 0, b);
    end
    tick; settle;
    check_idle("gap_after_r0");
    chk("last_grant_r0", 64'(dut.last_grant), 64'(0));
    tick; settle;
    check_beat("r1_burst", 1, 0);
    tick; settle;
    check_beat("r1_burst", 1, 1);

    // FIFO full stalls requester 1 for 5 cycles
    tick;
    fifo_full = 1'b1;
    settle;
    check_stall("full_stall", 1, 2);
    for (int f = 1; f < 5; f++) begin
      tick; settle;
      check_stall("full_stall", 1, 2);
    end
    tick;
    fifo_full = 1'b0;
    settle;
    check_beat("r1_resume", 1, 2);
    for (int b = 3; b < MB; b++) begin
      tick; settle;
      check_beat("r1_resume", 1, b);
    end
    tick;
    req_valid = 4'b1000;
    settle;
    check_idle("gap_after_r1");
    chk("last_grant_r1", 64'(dut.last_grant), 64'(1));

    // Requester 3 drops valid after 3 beats; next pick wraps to 0
    for (int b = 0; b < 3; b++) begin
      tick; settle;
      check_beat("r3_burst", 3, b);
    end
    tick;
    req_valid = 4'b0011;
    settle;
    chk("r3_drop_wr_en", 64'(fifo_wr_en), 64'(0));
    chk("r3_drop_ready", 64'(req_ready), 64'(0));
    chk("r3_drop_grant", 64'(grant), 64'(4'b1000));
    tick; settle;
    check_idle("r3_release");
    chk("last_grant_r3", 64'(dut.last_grant), 64'(3));
    tick; settle;
    check_beat("wrap_r0", 0, 0);

    // Reset pulse mid-burst after 4 beats
    for (int b = 1; b < 4; b++) begin
      tick; settle;
      check_beat("r0_pre_rst", 0, b);
    end
    tick;
    rst = 1'b1;
    settle;
    check_idle("rst_mid");
    chk("rst_mid_beat_cnt", 64'(dut.beat_cnt), 64'(0));
    chk("rst_mid_last_grant", 64'(dut.last_grant), 64'(NR - 1));
    tick;
    rst = 1'b0;
    settle;
    check_idle("post_rst_arb");
    tick; settle;
    check_beat("post_rst_r0", 0, 0);

    // fifo_ready falling ends the burst and blocks new grants
    tick;
    fifo_ready = 1'b0;
    settle;
    chk("nready_wr_en", 64'(fifo_wr_en), 64'(0));
    chk("nready_ready", 64'(req_ready), 64'(0));
    chk("nready_grant", 64'(grant), 64'(4'b0001));
    tick; settle;
    check_idle("nready_release");
    chk("last_grant_nready", 64'(dut.last_grant), 64'(0));
    tick; settle;
    check_idle("nready_hold");

    // Only requester 2 valid: 8 writes in every 9 cycles
    tick;
    fifo_ready = 1'b1;
    req_valid  = 4'b0100;
    settle;
    check_idle("r2_arb");
    writes = 0;
    for (int c = 0; c < 18; c++) begin
      tick; settle;
      if (c == 8 || c == 17) check_idle("r2_gap");
      else check_beat("r2_stream", 2, (c < 8) ? c : c - 9);
      writes += int'(fifo_wr_en);
    end
    chk("r2_write_count", 64'(writes), 64'(16));

    // Random valid/full traffic against a sequence scoreboard
    tick;
    req_valid = '0;
    settle;
    tick; tick; settle;
    check_idle("rand_start");
    for (int i = 0; i < NR; i++) begin
      seq[i]    = 0;
      starve[i] = 0;
    end
    prev_valid = '0;
    prev_grant = '0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (grant != '0 && prev_grant == '0) begin
        idx = oh2i(grant);
        chk("rand_onehot", 64'($onehot(grant)), 64'(1));
        chk("rand_grant_was_valid", 64'(prev_valid[idx]), 64'(1));
        for (int i = 0; i < NR; i++) begin
          if (i == idx || !prev_valid[i]) starve[i] = 0;
          else starve[i]++;
          chk("rand_starve", 64'(starve[i] <= NR - 1), 64'(1));
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i]) req_valid[i] = ($urandom_range(15) != 0);
        else req_valid[i] = ($urandom_range(3) == 0);
        if (!req_valid[i]) starve[i] = 0;
        req_data[i*W +: W] = {8'(i), 24'(seq[i])};
      end
      fifo_full  = ($urandom_range(4) == 0);
      prev_valid = req_valid;
      prev_grant = grant;
      settle;
      chk("rand_wr_while_full", 64'(fifo_wr_en && fifo_full), 64'(0));
      if (fifo_wr_en) begin
        idx = oh2i(grant);
        chk("rand_ready", 64'(req_ready), 64'(grant));
        chk("rand_data_order", 64'(fifo_wr_data), 64'({8'(idx), 24'(seq[idx])}));
        seq[idx]++;
      end else begin
        chk("rand_no_ready", 64'(req_ready), 64'(0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
